// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// Widths, requester ids and the holding-buffer entry layout.
package regarb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_PC_REG = 15;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  typedef struct packed {
    logic                  full;
    logic [DEF_ADDR_W-1:0] dest;
    logic [DEF_DATA_W-1:0] data;
    logic                  age;
  } buf_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channel: valid/ready handshake with dest and data.
// master drives the request, slave returns ready.
interface regfile_write_arbiter_if
  import regarb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output dest,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  dest,
    input  data,
    output ready
  );

endinterface

// File: rtl/regfile_write_arbiter_wb_hold_buf.sv
// One-entry writeback holding buffer with pass-through ready.
// A grant frees the slot in the same cycle a new request lands.
module wb_hold_buf
  import regarb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  regfile_write_arbiter_if.slave req,
  input  logic       grant,
  input  logic       age_new,
  input  logic       age_clr,
  output buf_entry_t entry
);

  logic accept;

  assign req.ready = !entry.full || grant;
  assign accept    = req.valid && req.ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      entry <= '0;
    end else if (accept) begin
      entry.full <= 1'b1;
      entry.dest <= req.dest;
      entry.data <= req.data;
      entry.age  <= age_new;
    end else if (grant) begin
      entry.full <= 1'b0;
      entry.age  <= 1'b0;
    end else if (age_clr) begin
      entry.age  <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto the single regfile write port.
// REGARB_FIXED_PRIO_EN: different-dest conflicts always favour mem.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_REG = DEF_PC_REG
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_write_arbiter_if.slave alu,
  regfile_write_arbiter_if.slave mem,
  output logic                 writeEnable,
  output logic [ADDR_W-1:0]    writeDestination,
  output logic [DATA_W-1:0]    writeData,
  output logic                 pcWrite,
  output logic [DATA_W-1:0]    pcData,
  output logic [2**ADDR_W-1:0] busy
);

  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_REG);

  buf_entry_t alu_e;
  buf_entry_t mem_e;
  buf_entry_t sel;
  logic       gnt_alu;
  logic       gnt_mem;
  logic       any_gnt;
  logic       to_pc;
  logic       age_alu;
  logic       age_mem;
  logic       alu_older;
  logic       same_dest;

`ifndef REGARB_FIXED_PRIO_EN
  req_e       last;
`endif

  // age=1 marks the younger entry: it landed while the other stayed put
  assign age_alu   = mem_e.full && !gnt_mem;
  assign age_mem   = alu_e.full && !gnt_alu;
  assign alu_older = mem_e.age && !alu_e.age;
  assign same_dest = alu_e.dest == mem_e.dest;

  wb_hold_buf u_alu_buf (
    .clk     (clk),
    .reset   (reset),
    .req     (alu),
    .grant   (gnt_alu),
    .age_new (age_alu),
    .age_clr (gnt_mem),
    .entry   (alu_e)
  );

  wb_hold_buf u_mem_buf (
    .clk     (clk),
    .reset   (reset),
    .req     (mem),
    .grant   (gnt_mem),
    .age_new (age_mem),
    .age_clr (gnt_alu),
    .entry   (mem_e)
  );

  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    unique case (1'b1)
      (alu_e.full && !mem_e.full): gnt_alu = 1'b1;
      (mem_e.full && !alu_e.full): gnt_mem = 1'b1;
      (alu_e.full && mem_e.full && same_dest): begin
        gnt_alu = alu_older;
        gnt_mem = !alu_older;
      end
      (alu_e.full && mem_e.full && !same_dest): begin
`ifdef REGARB_FIXED_PRIO_EN
        gnt_mem = 1'b1;
`else
        gnt_alu = last == REQ_MEM;
        gnt_mem = last == REQ_ALU;
`endif
      end
      default: ;
    endcase
  end

  assign any_gnt = gnt_alu || gnt_mem;
  assign sel     = gnt_mem ? mem_e : alu_e;
  assign to_pc   = sel.dest == PC_IDX;

  always_ff @(posedge clk) begin
    if (!reset) begin
      writeEnable      <= 1'b0;
      pcWrite          <= 1'b0;
      writeDestination <= '0;
      writeData        <= '0;
      pcData           <= '0;
`ifndef REGARB_FIXED_PRIO_EN
      last             <= REQ_MEM;
`endif
    end else begin
      writeEnable <= any_gnt && !to_pc;
      pcWrite     <= any_gnt && to_pc;
      if (any_gnt) begin
        writeDestination <= sel.dest;
        writeData        <= sel.data;
`ifndef REGARB_FIXED_PRIO_EN
        last             <= gnt_mem ? REQ_MEM : REQ_ALU;
`endif
      end
      if (any_gnt && to_pc) begin
        pcData <= sel.data;
      end
    end
  end

  always_comb begin
    busy = '0;
    if (alu_e.full) busy[alu_e.dest] = 1'b1;
    if (mem_e.full) busy[mem_e.dest] = 1'b1;
    if (writeEnable || pcWrite) busy[writeDestination] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter.
// Directed writes push expected commits; a monitor checks each strobe.
module tb_regfile_write_arbiter;
  import regarb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        writeEnable;
  logic        pcWrite;
  logic [3:0]  writeDestination;
  logic [31:0] writeData;
  logic [31:0] pcData;
  logic [15:0] busy;

  always #5 clk = ~clk;

  regfile_write_arbiter_if alu_if ();
  regfile_write_arbiter_if mem_if ();

  regfile_write_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .alu              (alu_if),
    .mem              (mem_if),
    .writeEnable      (writeEnable),
    .writeDestination (writeDestination),
    .writeData        (writeData),
    .pcWrite          (pcWrite),
    .pcData           (pcData),
    .busy             (busy)
  );

  typedef struct {
    logic        pc;
    logic [3:0]  dest;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests   = 0;
  int   fails   = 0;
  int   strobes = 0;
  logic mon_ok;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic pc, input logic [3:0] d,
                      input logic [31:0] x);
    exp_t e;
    e.pc   = pc;
    e.dest = d;
    e.data = x;
    sb.push_back(e);
  endtask

  task automatic send(input logic av, input logic [3:0] ad,
                      input logic [31:0] ax, input logic mv,
                      input logic [3:0] md, input logic [31:0] mx);
    alu_if.valid = av;
    alu_if.dest  = ad;
    alu_if.data  = ax;
    mem_if.valid = mv;
    mem_if.dest  = md;
    mem_if.data  = mx;
    tick();
    alu_if.valid = 1'b0;
    mem_if.valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && (writeEnable || pcWrite)) begin
      strobes++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: we=%b pc=%b dest=%0d data=%h",
                 writeEnable, pcWrite, writeDestination, writeData);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.pc)
          mon_ok = pcWrite && !writeEnable && pcData == mon_e.data;
        else
          mon_ok = writeEnable && !pcWrite &&
                   writeDestination == mon_e.dest &&
                   writeData == mon_e.data;
        if (!mon_ok) begin
          fails++;
          $display("FAIL commit: got we=%b pc=%b dest=%0d wd=%h pcd=%h expected pc=%b dest=%0d data=%h",
                   writeEnable, pcWrite, writeDestination, writeData,
                   pcData, mon_e.pc, mon_e.dest, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   k;
    int   low;
    int   s0;
    logic ar;
    logic mr;
    logic mem_done;

    reset        = 1'b0;
    alu_if.valid = 1'b1;
    alu_if.dest  = 4'd3;
    alu_if.data  = 32'hDEAD0001;
    mem_if.valid = 1'b1;
    mem_if.dest  = 4'd4;
    mem_if.data  = 32'hDEAD0002;
    repeat (2) begin
      @(negedge clk);
      chk("reset_we", writeEnable, 0);
      chk("reset_pcw", pcWrite, 0);
      chk("reset_busy", busy, 0);
      chk("reset_wdata", writeData, 0);
      chk("reset_pcdata", pcData, 0);
    end
    tick();
    alu_if.valid = 1'b0;
    mem_if.valid = 1'b0;
    reset        = 1'b1;
    tick();

    push(0, 4'd3, 32'hAAAAAAAA);
    send(1, 4'd3, 32'hAAAAAAAA, 0, 4'd0, 0);
    @(negedge clk);
    chk("single_busy_e", busy[3], 1);
    chk("single_we_e", writeEnable, 0);
    tick();
    @(negedge clk);
    chk("single_we_e1", writeEnable, 1);
    chk("single_busy_e1", busy[3], 1);
    tick();
    @(negedge clk);
    chk("single_busy_end", busy, 0);
    chk("single_we_end", writeEnable, 0);
    tick();

    push(0, 4'd2, 32'h2);
    push(0, 4'd2, 32'h1);
    send(1, 4'd2, 32'h1, 1, 4'd2, 32'h2);
    @(negedge clk);
    chk("same_alu_wait", alu_if.ready, 0);
    chk("same_busy", busy[2], 1);
    tick();
    @(negedge clk);
    chk("same_first_we", writeEnable, 1);
    tick();
    @(negedge clk);
    chk("same_second_we", writeEnable, 1);
    repeat (3) tick();

    push(0, 4'd5, 32'h55);
    push(0, 4'd4, 32'h44);
    send(1, 4'd4, 32'h44, 1, 4'd5, 32'h55);
    repeat (4) tick();

    push(1, 4'd15, 32'h100);
    send(0, 4'd0, 0, 1, 4'd15, 32'h100);
    tick();
    @(negedge clk);
    chk("pc_pcw", pcWrite, 1);
    chk("pc_we", writeEnable, 0);
    chk("pc_data", pcData, 32'h100);
    repeat (2) tick();

`ifdef REGARB_FIXED_PRIO_EN
    push(0, 4'd5, 32'h5A);
    push(0, 4'd4, 32'h4A);
    send(1, 4'd4, 32'h4A, 1, 4'd5, 32'h5A);
    @(negedge clk);
    chk("prio_alu_wait", alu_if.ready, 0);
`else
    push(0, 4'd4, 32'h4A);
    push(0, 4'd5, 32'h5A);
    send(1, 4'd4, 32'h4A, 1, 4'd5, 32'h5A);
    @(negedge clk);
    chk("rr_mem_wait", mem_if.ready, 0);
`endif
    repeat (4) tick();

    s0 = strobes;
    for (int i = 0; i < 8; i++) begin
      alu_if.valid = 1'b1;
      alu_if.dest  = 4'(i + 1);
      alu_if.data  = 32'h1000 + i;
      push(0, 4'(i + 1), 32'h1000 + i);
      @(negedge clk);
      chk("stream_ready", alu_if.ready, 1);
      if (i >= 2) chk("stream_we", writeEnable, 1);
      tick();
    end
    alu_if.valid = 1'b0;
    @(negedge clk);
    chk("stream_we_6", writeEnable, 1);
    tick();
    @(negedge clk);
    chk("stream_we_7", writeEnable, 1);
    tick();
    @(negedge clk);
    chk("stream_we_off", writeEnable, 0);
    chk("stream_count", strobes - s0, 8);
    tick();

    push(0, 4'd10, 32'h2000);
    push(0, 4'd11, 32'h2001);
    push(0, 4'd9, 32'h9999);
    for (int j = 2; j < 6; j++)
      push(0, 4'(10 + j % 4), 32'h2000 + j);
    k        = 0;
    low      = 0;
    mem_done = 1'b0;
    for (int c = 0; c < 30 && k < 6; c++) begin
      alu_if.valid = 1'b1;
      alu_if.dest  = 4'(10 + k % 4);
      alu_if.data  = 32'h2000 + k;
      mem_if.valid = c >= 2 && !mem_done;
      mem_if.dest  = 4'd9;
      mem_if.data  = 32'h9999;
      @(negedge clk);
      ar = alu_if.ready;
      mr = mem_if.ready;
      if (!ar) low++;
      @(posedge clk);
      if (ar) k++;
      if (mem_if.valid && mr) mem_done = 1'b1;
      #1;
    end
    alu_if.valid = 1'b0;
    mem_if.valid = 1'b0;
    chk("inj_done", k, 6);
    chk("inj_mem_done", mem_done, 1);
    chk("inj_ready_low", low, 1);
    repeat (6) tick();

    send(1, 4'd6, 32'h66, 1, 4'd7, 32'h77);
    @(negedge clk);
    chk("mid_busy_full", busy, 16'h00C0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_busy_clear", busy, 0);
    repeat (4) begin
      tick();
      @(negedge clk);
      chk("mid_no_we", writeEnable, 0);
      chk("mid_no_pcw", pcWrite, 0);
    end
    tick();

`ifdef REGARB_FIXED_PRIO_EN
    push(0, 4'd5, 32'hB5);
    push(0, 4'd4, 32'hA4);
    send(1, 4'd4, 32'hA4, 1, 4'd5, 32'hB5);
    @(negedge clk);
    chk("ptr_alu_wait", alu_if.ready, 0);
`else
    push(0, 4'd4, 32'hA4);
    push(0, 4'd5, 32'hB5);
    send(1, 4'd4, 32'hA4, 1, 4'd5, 32'hB5);
    @(negedge clk);
    chk("ptr_mem_wait", mem_if.ready, 0);
`endif
    repeat (5) tick();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
